// File: rtl/note_distributor.sv
// Note distributor: accepts notes from the song reader and hands each one to a free
// note player via a one-cycle load strobe, choosing players by round-robin search.
module note_distributor #(
   parameter int unsigned NUM_PLAYERS = 3,
   parameter int unsigned NOTE_W      = 6,
   parameter int unsigned DUR_W       = 6,
   localparam int unsigned PTR_W      = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
   localparam int unsigned CNT_W      = $clog2(NUM_PLAYERS + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   play_enable,
   input  logic                   note_valid,
   input  logic [NOTE_W-1:0]      note_in,
   input  logic [DUR_W-1:0]       duration_in,
   output logic                   note_ready,
   input  logic [NUM_PLAYERS-1:0] player_playing,
   output logic [NUM_PLAYERS-1:0] load_new_note,
   output logic [NOTE_W-1:0]      note_to_load,
   output logic [DUR_W-1:0]       duration_to_load,
   output logic                   all_busy,
   output logic [CNT_W-1:0]       active_count
);

   typedef enum logic [1:0] {IDLE, DISPATCH, SETTLE} state_t;

   state_t                 state, state_nxt;
   logic [NUM_PLAYERS-1:0] reserved;
   logic [NUM_PLAYERS-1:0] free;
   logic [NUM_PLAYERS-1:0] sel_onehot;
   logic [PTR_W-1:0]       rr_ptr;
   logic [PTR_W-1:0]       sel_idx;
   logic [PTR_W-1:0]       sel_q;
   logic [PTR_W-1:0]       cand;
   logic                   sel_found;
   logic                   is_rest;
   logic                   accept;
   logic                   dispatch_go;

   // A player reserved for an in-flight load is not free until its playing flag is up.
   assign free       = ~player_playing & ~reserved;
   assign is_rest    = (note_in == '0);
   assign all_busy   = ~|free;
   assign note_ready = reset & (state == IDLE) & play_enable & (~all_busy | is_rest);
   assign accept     = note_valid & note_ready;
   assign dispatch_go = accept & ~is_rest;

   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int unsigned off = 0; off < NUM_PLAYERS; off++) begin
         cand = PTR_W'((32'(rr_ptr) + off) % NUM_PLAYERS);
         if (!sel_found && free[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
      sel_onehot = NUM_PLAYERS'(1) << sel_idx;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:     if (dispatch_go) state_nxt = DISPATCH;
         DISPATCH: state_nxt = SETTLE;
         SETTLE:   state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr           <= '0;
         reserved         <= '0;
         sel_q            <= '0;
         load_new_note    <= '0;
         note_to_load     <= '0;
         duration_to_load <= '0;
         active_count     <= '0;
      end else begin
         load_new_note <= '0;
         active_count  <= CNT_W'($countones(player_playing));
         unique case (state)
            IDLE: begin
               if (dispatch_go) begin
                  note_to_load     <= note_in;
                  duration_to_load <= duration_in;
                  reserved         <= reserved | sel_onehot;
                  sel_q            <= sel_idx;
                  load_new_note    <= sel_onehot;
               end
            end
            DISPATCH: rr_ptr <= (32'(sel_q) + 32'd1 >= NUM_PLAYERS) ? '0 : sel_q + 1'b1;
            SETTLE:   reserved <= '0;
            default:  ;
         endcase
      end
   end

endmodule

// File: tb/tb_note_distributor.sv
// Bench for note_distributor: directed scenarios followed by randomized traffic, all
// checked cycle by cycle against a phase-counter reference model of the distributor.
module tb_note_distributor;
   localparam int N = 3;

   logic         clk;
   logic         reset;
   logic         play_enable;
   logic         note_valid;
   logic [5:0]   note_in;
   logic [5:0]   duration_in;
   logic         note_ready;
   logic [N-1:0] player_playing;
   logic [N-1:0] load_new_note;
   logic [5:0]   note_to_load;
   logic [5:0]   duration_to_load;
   logic         all_busy;
   logic [1:0]   active_count;

   int n_cmp = 0;
   int n_fail = 0;

   // reference model: phase 0 = can accept, 1 = strobe cycle, 2 = gap cycle
   int         m_phase, m_pend, m_rr, m_cnt;
   logic [5:0] m_note, m_dur;
   int         ptime[N];
   bit         auto_pl;
   int         len_lo, len_hi;

   note_distributor #(.NUM_PLAYERS(N), .NOTE_W(6), .DUR_W(6)) dut (
      .clk(clk), .reset(reset), .play_enable(play_enable), .note_valid(note_valid),
      .note_in(note_in), .duration_in(duration_in), .note_ready(note_ready),
      .player_playing(player_playing), .load_new_note(load_new_note),
      .note_to_load(note_to_load), .duration_to_load(duration_to_load),
      .all_busy(all_busy), .active_count(active_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, observed running expected finished");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit is_free(int i);
      return !bit'(player_playing >> i) && !(m_phase != 0 && m_pend == i);
   endfunction

   function automatic bit any_free();
      bit r = 1'b0;
      for (int i = 0; i < N; i++) if (is_free(i)) r = 1'b1;
      return r;
   endfunction

   function automatic bit exp_ready();
      return reset && m_phase == 0 && play_enable && (any_free() || note_in == 6'd0);
   endfunction

   function automatic logic [N-1:0] exp_strobe();
      return (m_phase == 1) ? (N'(1) << m_pend) : '0;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_pend = -1; m_rr = 0; m_note = '0; m_dur = '0; m_cnt = 0;
   endtask

   task automatic set_reset(input logic v);
      reset = v;
      if (!v) model_reset();
   endtask

   task automatic check_outputs();
      chk("note_ready", 32'(note_ready), 32'(exp_ready()));
      chk("all_busy", 32'(all_busy), 32'(!any_free()));
      chk("load_new_note", 32'(load_new_note), 32'(exp_strobe()));
      chk("note_to_load", 32'(note_to_load), 32'(m_note));
      chk("duration_to_load", 32'(duration_to_load), 32'(m_dur));
      chk("active_count", 32'(active_count), 32'(m_cnt));
   endtask

   task automatic model_edge();
      bit           acc;
      int           k;
      logic [N-1:0] strb;
      acc  = note_valid && exp_ready();
      strb = exp_strobe();
      if (!reset) begin
         model_reset();
      end else begin
         m_cnt = $countones(player_playing);
         case (m_phase)
            1: begin m_rr = (m_pend + 1) % N; m_phase = 2; end
            2: begin m_phase = 0; m_pend = -1; end
            default: begin
               if (acc && note_in != 6'd0) begin
                  k = -1;
                  for (int off = 0; off < N; off++) begin
                     int c = (m_rr + off) % N;
                     if (k < 0 && is_free(c)) k = c;
                  end
                  m_pend = k; m_note = note_in; m_dur = duration_in; m_phase = 1;
               end
            end
         endcase
      end
      for (int i = 0; i < N; i++) begin
         if (ptime[i] > 0) ptime[i]--;
         if (auto_pl && bit'(strb >> i)) ptime[i] = $urandom_range(len_hi, len_lo);
      end
   endtask

   task automatic drive_players();
      logic [N-1:0] pp = '0;
      if (auto_pl) begin
         for (int i = 0; i < N; i++) if (ptime[i] != 0) pp = pp | (N'(1) << i);
         player_playing = pp;
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_edge();
      #1;
      drive_players();
   endtask

   task automatic send(input logic [5:0] n, input logic [5:0] d, output int cyc);
      bit acc = 1'b0;
      note_in = n; duration_in = d; note_valid = 1'b1; cyc = 0;
      while (!acc && cyc < 40) begin
         acc = exp_ready();
         cycle();
         cyc++;
      end
      note_valid = 1'b0;
      chk("send_accepted", 32'(acc), 32'd1);
   endtask

   task automatic strobe_is(input string tag, input logic [N-1:0] exp);
      #1;
      chk(tag, 32'(load_new_note), 32'(exp));
   endtask

   initial begin
      int c;
      reset = 1'b1; play_enable = 1'b0; note_valid = 1'b0; note_in = '0; duration_in = '0;
      player_playing = '0; auto_pl = 1'b0; len_lo = 1; len_hi = 10;
      for (int i = 0; i < N; i++) ptime[i] = 0;
      model_reset();
      #1 set_reset(1'b0);
      #2;
      chk("rst_ready", 32'(note_ready), 32'd0);
      chk("rst_strobe", 32'(load_new_note), 32'd0);
      chk("rst_note", 32'(note_to_load), 32'd0);
      chk("rst_dur", 32'(duration_to_load), 32'd0);
      chk("rst_count", 32'(active_count), 32'd0);
      repeat (3) cycle();

      // first note after reset goes to player 0
      set_reset(1'b1); play_enable = 1'b1;
      send(6'd10, 6'd8, c);
      strobe_is("t1_strobe", 3'b001);
      chk("t1_note", 32'(note_to_load), 32'd10);
      chk("t1_dur", 32'(duration_to_load), 32'd8);

      // back-to-back notes with players that start playing after their strobe
      cycle(); cycle(); set_reset(1'b0); cycle(); set_reset(1'b1);
      auto_pl = 1'b1; len_lo = 30; len_hi = 30;
      send(6'd20, 6'd4, c); strobe_is("t2_strobe0", 3'b001);
      send(6'd21, 6'd5, c); chk("t2_gap1", 32'(c), 32'd3); strobe_is("t2_strobe1", 3'b010);
      send(6'd22, 6'd6, c); chk("t2_gap2", 32'(c), 32'd3); strobe_is("t2_strobe2", 3'b100);

      // all busy, then player 1 frees
      auto_pl = 1'b0; player_playing = 3'b111;
      cycle(); cycle();
      note_in = 6'd5; duration_in = 6'd9; note_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle(); #1;
         chk("t3_ready_low", 32'(note_ready), 32'd0);
         chk("t3_all_busy", 32'(all_busy), 32'd1);
      end
      player_playing = 3'b101;
      send(6'd5, 6'd9, c); chk("t3_wait", 32'(c), 32'd1); strobe_is("t3_strobe", 3'b010);

      // rest while all busy
      player_playing = 3'b111;
      cycle(); cycle();
      note_in = 6'd0; duration_in = 6'd3; note_valid = 1'b1; #1;
      chk("t4_rest_ready", 32'(note_ready), 32'd1);
      send(6'd0, 6'd3, c); chk("t4_rest_wait", 32'(c), 32'd1);
      #1;
      chk("t4_no_strobe", 32'(load_new_note), 32'd0);
      chk("t4_bus_hold", 32'(note_to_load), 32'd5);
      player_playing = 3'b000;
      send(6'd7, 6'd4, c); strobe_is("t4_rr_kept", 3'b100);

      // play_enable gating, and drop during dispatch
      cycle(); cycle();
      play_enable = 1'b0; note_in = 6'd9; duration_in = 6'd2; note_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle(); #1;
         chk("t5_ready_low", 32'(note_ready), 32'd0);
         chk("t5_no_strobe", 32'(load_new_note), 32'd0);
      end
      play_enable = 1'b1;
      send(6'd9, 6'd2, c);
      play_enable = 1'b0;
      strobe_is("t5_strobe_kept", 3'b001);
      repeat (3) cycle();
      play_enable = 1'b1;

      // reset during dispatch
      send(6'd11, 6'd6, c); strobe_is("t6_strobe", 3'b010);
      set_reset(1'b0); #1;
      chk("t6_drop", 32'(load_new_note), 32'd0);
      chk("t6_note", 32'(note_to_load), 32'd0);
      chk("t6_dur", 32'(duration_to_load), 32'd0);
      cycle(); cycle();
      set_reset(1'b1);
      send(6'd12, 6'd5, c); strobe_is("t6_after", 3'b001);

      // randomized traffic
      for (int i = 0; i < N; i++) ptime[i] = 0;
      auto_pl = 1'b1; len_lo = 1; len_hi = 10;
      drive_players();
      for (int i = 0; i < 800; i++) begin
         play_enable = ($urandom % 10) != 0;
         note_valid  = ($urandom % 10) < 7;
         note_in     = ($urandom % 5 == 0) ? 6'd0 : 6'($urandom_range(63, 1));
         duration_in = 6'($urandom);
         if (!reset) set_reset(1'b1);
         else if ($urandom % 150 == 0) set_reset(1'b0);
         cycle();
      end
      note_valid = 1'b0;
      cycle(); cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
